// File: rtl/uart_tx_sb_ctrl.sv
// Bus-programmable UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_SB_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry TX FIFO.
module uart_tx_sb_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd5208,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic [31:0] WD_i,
    input  logic        WE_i,
    output logic [31:0] RD_o,
    output logic        tx_o
);
    localparam logic [31:0] ADDR_DATA  = 32'h00;
    localparam logic [31:0] ADDR_BUSY  = 32'h08;
    localparam logic [31:0] ADDR_BAUD  = 32'h0C;
    localparam logic [31:0] ADDR_PAR   = 32'h10;
    localparam logic [31:0] ADDR_STOP  = 32'h14;
    localparam logic [31:0] ADDR_COUNT = 32'h1C;
    localparam logic [31:0] ADDR_RST   = 32'h24;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_reg;
    logic [15:0] baud_reg;
    logic        parity_en_reg;
    logic        stopbit_reg;
    logic [15:0] timer_reg;
    logic [2:0]  bit_idx_reg;
    logic        stop_idx_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;
    logic [31:0] rd_reg;

    logic        wr_en;
    logic        rd_en;
    logic        wr_data;
    logic        wr_baud;
    logic        wr_par;
    logic        wr_stop;
    logic        soft_rst;
    logic [15:0] div_last;
    logic        bit_done;
    logic        frame_end;
    logic        src_valid;
    logic [7:0]  src_byte;
    logic        load;
    logic        busy_status;
    logic        cfg_ok;
    logic [31:0] count_status;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign wr_en    = req_i & WE_i;
    assign rd_en    = req_i & ~WE_i;
    assign wr_data  = wr_en && (addr_i == ADDR_DATA);
    assign wr_baud  = wr_en && (addr_i == ADDR_BAUD);
    assign wr_par   = wr_en && (addr_i == ADDR_PAR);
    assign wr_stop  = wr_en && (addr_i == ADDR_STOP);
    assign soft_rst = wr_en && (addr_i == ADDR_RST) && WD_i[0];

    // A programmed divisor of 0 behaves as 1 cycle per bit.
    assign div_last  = (baud_reg == 16'd0) ? 16'd0 : baud_reg - 16'd1;
    assign bit_done  = (timer_reg == div_last);
    assign frame_end = (state_reg == STOP) && bit_done && (stop_idx_reg == stopbit_reg);
    assign load      = src_valid && ((state_reg == IDLE) || frame_end);

`ifdef UART_TX_SB_FIFO_EN
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push;

    assign push         = wr_data && (count_reg != FULL_COUNT);
    assign src_valid    = (count_reg != '0);
    assign src_byte     = fifo_mem[rd_ptr_reg];
    assign busy_status  = (count_reg == FULL_COUNT);
    assign cfg_ok       = (count_reg == '0) && (state_reg == IDLE);
    assign count_status = {{(31 - PTR_W){1'b0}}, count_reg};
    assign unused_bits  = ^WD_i[31:16];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= WD_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (soft_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
`else
    logic busy_reg;

    assign src_valid    = wr_data && !busy_reg;
    assign src_byte     = WD_i[7:0];
    assign busy_status  = busy_reg;
    assign cfg_ok       = !busy_reg;
    assign count_status = '0;
    assign unused_bits  = ^{WD_i[31:16], FIFO_DEPTH[0]};

    // busy_reg spans exactly the frame: set on the accepting edge, cleared on the last stop-bit edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_reg <= 1'b0;
        end else if (soft_rst) begin
            busy_reg <= 1'b0;
        end else if (load) begin
            busy_reg <= 1'b1;
        end else if (frame_end) begin
            busy_reg <= 1'b0;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_BUSY:  rd_mux = {31'd0, busy_status};
            ADDR_BAUD:  rd_mux = {16'd0, baud_reg};
            ADDR_PAR:   rd_mux = {31'd0, parity_en_reg};
            ADDR_STOP:  rd_mux = {31'd0, stopbit_reg};
            ADDR_COUNT: rd_mux = count_status;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            baud_reg      <= DEFAULT_DIV;
            parity_en_reg <= 1'b0;
            stopbit_reg   <= 1'b0;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            shift_reg     <= '0;
            tx_reg        <= 1'b1;
            rd_reg        <= '0;
        end else if (soft_rst) begin
            state_reg     <= IDLE;
            baud_reg      <= DEFAULT_DIV;
            parity_en_reg <= 1'b0;
            stopbit_reg   <= 1'b0;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            shift_reg     <= '0;
            tx_reg        <= 1'b1;
            rd_reg        <= '0;
        end else begin
            if (rd_en) begin
                rd_reg <= rd_mux;
            end
            if (cfg_ok) begin
                if (wr_baud) baud_reg      <= WD_i[15:0];
                if (wr_par)  parity_en_reg <= WD_i[0];
                if (wr_stop) stopbit_reg   <= WD_i[0];
            end

            if (state_reg == IDLE) begin
                timer_reg <= '0;
                tx_reg    <= 1'b1;
                if (load) begin
                    shift_reg <= src_byte;
                    tx_reg    <= 1'b0;
                    state_reg <= START;
                end
            end else if (!bit_done) begin
                timer_reg <= timer_reg + 16'd1;
            end else begin
                timer_reg <= '0;
                case (state_reg)
                    START: begin
                        state_reg <= DATA;
                        tx_reg    <= shift_reg[0];
                    end
                    DATA: begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            if (parity_en_reg) begin
                                state_reg <= PARITY;
                                tx_reg    <= ^shift_reg;
                            end else begin
                                state_reg    <= STOP;
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                            end
                        end else begin
                            tx_reg <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end
                    PARITY: begin
                        state_reg    <= STOP;
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                    end
                    STOP: begin
                        if (stop_idx_reg != stopbit_reg) begin
                            stop_idx_reg <= 1'b1;
                        end else if (load) begin
                            // Next queued byte starts immediately after the last stop bit.
                            stop_idx_reg <= 1'b0;
                            shift_reg    <= src_byte;
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            stop_idx_reg <= 1'b0;
                            tx_reg       <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        tx_reg    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign RD_o = rd_reg;
    assign tx_o = tx_reg;
endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Scoreboard bench for uart_tx_sb_ctrl: bus stimulus queues expected frames and read data,
// a negedge monitor decodes tx_o cycle by cycle and checks RD_o after every read.
module tb_uart_tx_sb_ctrl;
    localparam logic [15:0] DEF_DIV = 16'd5208;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        tx;

    uart_tx_sb_ctrl #(.DEFAULT_DIV(DEF_DIV), .FIFO_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .addr_i(addr),
        .req_i (req),
        .WD_i  (wd),
        .WE_i  (we),
        .RD_o  (rd),
        .tx_o  (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
        int          start;
        logic [7:0]  data;
    } frame_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rdexp_t;

    frame_t exp_q[$];
    rdexp_t rd_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rd_seen = 1'b0;
    int abort_cnt = 0;
    int abort_seen = 0;
    bit end_req = 0;
    bit end_done = 0;

    // Reference model state: configuration and the edge window in which busy reads 1.
    int m_baud;
    bit m_par;
    bit m_stop;
    int m_start;
    int m_end;

    function automatic void model_reset();
        m_baud  = int'(DEF_DIV);
        m_par   = 0;
        m_stop  = 0;
        m_start = -1;
        m_end   = -1;
    endfunction

    function automatic bit m_busy(input int e);
        return (e > m_start) && (e <= m_end);
    endfunction

    function automatic frame_t make_frame(input logic [7:0] d, input int e);
        frame_t f;
        int n;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[i + 1] = d[i];
        n = 9;
        if (m_par) begin
            f.bits[n] = ^d;
            n = n + 1;
        end
        f.bits[n] = 1'b1;
        n = n + 1;
        if (m_stop) begin
            f.bits[n] = 1'b1;
            n = n + 1;
        end
        f.nbits = n;
        f.div   = (m_baud == 0) ? 1 : m_baud;
        f.start = e;
        f.data  = d;
        return f;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int e);
        case (a)
            32'h08:  return {31'd0, m_busy(e)};
            32'h0C:  return 32'(m_baud);
            32'h10:  return {31'd0, m_par};
            32'h14:  return {31'd0, m_stop};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= req && !we;
    end

    // Each task is entered 1 time unit after a rising edge and returns at the same phase one cycle later.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        int e;
        frame_t f;
        e = cyc + 1;
        addr = a;
        wd   = d;
        we   = 1'b1;
        req  = 1'b1;
        if (a == 32'h24) begin
            if (d[0]) model_reset();
        end else if (!m_busy(e)) begin
            case (a)
                32'h00: begin
                    f = make_frame(d[7:0], e);
                    exp_q.push_back(f);
                    m_start = e;
                    m_end   = e + f.nbits * f.div;
                end
                32'h0C: m_baud = int'(d[15:0]);
                32'h10: m_par  = d[0];
                32'h14: m_stop = d[0];
                default: ;
            endcase
        end
        $display("write [%h] <= %h at edge %0d", a, d, e);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        rdexp_t r;
        r.addr = a;
        r.exp  = model_read(a, cyc + 1);
        rd_q.push_back(r);
        addr = a;
        we   = 1'b0;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_edge(input int t);
        while (cyc + 1 < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    bit     mon_active = 0;
    int     mon_k;
    int     mon_got_start;
    int     mon_bad_k;
    logic   mon_bad_got;
    logic   mon_bad_exp;
    frame_t cur;
    rdexp_t rr;

    always @(negedge clk) begin
        if (rd_seen) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL read_unexpected: RD_o=%h with no read queued", rd);
            end else begin
                rr = rd_q.pop_front();
                if (rd !== rr.exp) begin
                    miscompares++;
                    $display("FAIL read[%h]: got %h, required %h", rr.addr, rd, rr.exp);
                end else begin
                    $display("read  [%h] -> %h", rr.addr, rd);
                end
            end
        end

        if (abort_cnt != abort_seen) begin
            abort_seen = abort_cnt;
            vectors++;
            if (tx !== 1'b1 || rd !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_state: tx_o=%b RD_o=%h, required tx_o=1 RD_o=00000000", tx, rd);
            end else begin
                $display("reset tx_o=1 RD_o=0%s", mon_active ? ", frame abandoned" : "");
            end
            if (mon_active && (mon_bad_k >= 0 || mon_got_start != cur.start)) begin
                vectors++;
                miscompares++;
                $display("FAIL frame[%02h] before reset: start %0d (required %0d), bad cycle %0d tx_o=%b (required %b)",
                         cur.data, mon_got_start, cur.start, mon_bad_k, mon_bad_got, mon_bad_exp);
            end
            mon_active = 0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_start: tx_o=0 at cycle %0d, required idle 1 (no frame pending)", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    mon_active    = 1;
                    mon_k         = 0;
                    mon_got_start = cyc;
                    mon_bad_k     = -1;
                end
            end
            if (mon_active) begin
                if (tx !== cur.bits[mon_k / cur.div] && mon_bad_k < 0) begin
                    mon_bad_k   = mon_k;
                    mon_bad_got = tx;
                    mon_bad_exp = cur.bits[mon_k / cur.div];
                end
                mon_k++;
                if (mon_k == cur.nbits * cur.div) begin
                    vectors++;
                    if (mon_bad_k >= 0 || mon_got_start != cur.start) begin
                        miscompares++;
                        $display("FAIL frame[%02h]: start %0d (required %0d), bad cycle %0d tx_o=%b (required %b)",
                                 cur.data, mon_got_start, cur.start, mon_bad_k, mon_bad_got, mon_bad_exp);
                    end else begin
                        $display("frame %02h: %0d bits x %0d cycles from cycle %0d", cur.data, cur.nbits, cur.div, cur.start);
                    end
                    mon_active = 0;
                end
            end
        end

        if (end_req && !end_done) begin
            vectors++;
            if (exp_q.size() != 0 || mon_active || rd_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: %0d frames, %0d reads outstanding, active=%0d, required 0/0/0",
                         exp_q.size(), rd_q.size(), mon_active);
            end else begin
                $display("drain: scoreboards empty");
            end
            end_done = 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    logic [31:0] ra [8];
    int e0;

    initial begin
        ra = '{32'h00, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h24, 32'h40};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        abort_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset values and unmapped read.
        bus_read(32'h0C);
        bus_read(32'h08);
        bus_read(32'h10);
        bus_read(32'h14);
        bus_read(32'h1C);
        bus_read(32'h40);

        // 0xA5 with even parity, 4 cycles per bit; probe busy at its last high edge and first low edge.
        bus_write(32'h0C, 32'd4);
        bus_write(32'h10, 32'd1);
        bus_write(32'h14, 32'd0);
        bus_write(32'h00, 32'h0000_00A5);
        wait_edge(m_end);
        bus_read(32'h08);
        bus_read(32'h08);

        // 0x00 with 2 stop bits; writes during the frame and on the busy-clear edge are dropped.
        bus_write(32'h0C, 32'd2);
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd1);
        bus_write(32'h00, 32'h0000_0000);
        bus_write(32'h00, 32'h0000_003C);
        bus_write(32'h0C, 32'd8);
        bus_read(32'h0C);
        wait_edge(m_end);
        bus_write(32'h00, 32'h0000_0055);
        bus_read(32'h08);

        // Randomised frames with random bus traffic while busy.
        for (int it = 0; it < 30; it++) begin
            wait_edge(m_end + 1 + int'($urandom_range(0, 2)));
            bus_write(32'h0C, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 4));
            bus_write(32'h10, $urandom);
            bus_write(32'h14, $urandom);
            bus_write(32'h00, $urandom);
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                case ($urandom_range(0, 5))
                    0: bus_write(32'h00, $urandom);
                    1: bus_write(32'h0C, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 5));
                    2: bus_write(32'h10, $urandom);
                    3: bus_write(32'h14, $urandom);
                    4: bus_read(ra[$urandom_range(0, 7)]);
                    default: begin
                        repeat ($urandom_range(1, 6)) @(posedge clk);
                        #1;
                    end
                endcase
            end
        end

        // Asynchronous reset in the middle of the data bits.
        wait_edge(m_end + 1);
        bus_write(32'h0C, 32'd3);
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd0);
        e0 = cyc + 1;
        bus_write(32'h00, 32'h0000_0000);
        bus_read(32'h0C);
        wait_edge(e0 + 12);
        rst_n = 1'b0;
        abort_cnt++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_read(32'h08);
        bus_read(32'h0C);

        // Soft reset in the middle of the data bits; a write of 0 to the reset register does nothing.
        bus_write(32'h0C, 32'd3);
        e0 = cyc + 1;
        bus_write(32'h00, 32'h0000_0000);
        bus_read(32'h0C);
        bus_write(32'h24, 32'd0);
        wait_edge(e0 + 12);
        bus_write(32'h24, 32'd1);
        abort_cnt++;
        bus_read(32'h08);
        bus_read(32'h0C);

        // Frame after soft reset at the restored configuration's minimum divisor.
        bus_write(32'h0C, 32'd0);
        bus_write(32'h00, 32'h0000_0096);
        wait_edge(m_end + 3);
        repeat (2) @(posedge clk);
        #1;

        end_req = 1;
        for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
